// File: rtl/iot_stream_tx_pkg.sv
// Shared types and constants for the IoT data-filter transmit path.
package iotdf_pkg;
  localparam logic [2:0] FN_MAX     = 3'd1;
  localparam logic [2:0] FN_MIN     = 3'd2;
  localparam logic [2:0] FN_AVG     = 3'd3;
  localparam logic [2:0] FN_EXTRACT = 3'd4;
  localparam logic [2:0] FN_EXCLUDE = 3'd5;
  localparam logic [2:0] FN_PEAKMAX = 3'd6;
  localparam logic [2:0] FN_PEAKMIN = 3'd7;

  localparam int BYTES_PER_WORD  = 16;
  localparam int WORDS_PER_ROUND = 8;
  localparam int DATA_W          = 128;
  localparam int FN_W            = 3;

  typedef struct packed {
    logic [FN_W-1:0]   fn;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic logic [7:0] msb_byte(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 8];
  endfunction
endpackage

// File: rtl/iot_stream_tx_if.sv
// Upstream word handshake plus byte-serial filter link, bundled for iot_stream_tx.
interface iot_stream_tx_if;
  import iotdf_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [FN_W-1:0]   s_fn;
  logic              busy;
  logic              in_en;
  logic [7:0]        iot_in;
  logic [FN_W-1:0]   fn_sel;
  logic              round_done;

  modport slave (
    input  s_valid, s_data, s_fn, busy,
    output s_ready, in_en, iot_in, fn_sel, round_done
  );

  modport master (
    output s_valid, s_data, s_fn, busy,
    input  s_ready, in_en, iot_in, fn_sel, round_done
  );
endinterface

// File: rtl/iot_stream_tx_fifo.sv
// Generic synchronous FIFO, power-of-two depth, full/empty from a registered count.
// Latency: written entry visible on rdata the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together legal when not full.
module iot_tx_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 131
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/iot_stream_tx.sv
// Byte-serial transmitter: buffers 128-bit words and streams them MSB byte first to the filter.
// Latency: push at edge k, pop at k+1, first byte strobed in the cycle after k+1; 16 cycles/word.
// Backpressure: s_ready = !fifo_full (no same-cycle pop credit); busy stalls the byte stream in place.
module iot_stream_tx #(
  parameter int DEPTH           = 2,
  parameter int WORDS_PER_ROUND = iotdf_pkg::WORDS_PER_ROUND
) (
  input logic            clk,
  input logic            rst,
  iot_stream_tx_if.slave bus
);
  import iotdf_pkg::*;

  localparam int             WCW       = (WORDS_PER_ROUND > 1) ? $clog2(WORDS_PER_ROUND) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_ROUND - 1);
  localparam logic [3:0]     LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  fifo_entry_t       wr_entry;
  fifo_entry_t       rd_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        byte_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [WCW-1:0]    word_cnt_inc;
  logic [WCW-1:0]    pop_idx;
  logic [FN_W-1:0]   fn_sel_q;
  logic              round_done_q;
  logic              xfer;
  logic              word_end;

  assign wr_entry     = '{fn: bus.s_fn, data: bus.s_data};
  assign push         = bus.s_valid & ~fifo_full;
  assign xfer         = (state == ST_SEND) & ~bus.busy;
  assign word_end     = xfer & (byte_cnt == LAST_BYTE);
  assign word_cnt_inc = (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;

  iot_tx_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pop_idx is the round position of the word being popped, so a pop chained
  // at a word end already sees the advanced word counter.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pop_idx   = word_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (word_end) begin
          pop_idx = word_cnt_inc;
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg        <= '0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      fn_sel_q     <= '0;
      round_done_q <= 1'b0;
    end else begin
      round_done_q <= word_end & (word_cnt == LAST_WORD);
      if (word_end) word_cnt <= word_cnt_inc;
      if (pop) begin
        shreg    <= rd_entry.data;
        byte_cnt <= '0;
        if (pop_idx == '0) fn_sel_q <= rd_entry.fn;
      end else if (xfer) begin
        shreg    <= {shreg[DATA_W-9:0], 8'h00};
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  assign bus.s_ready    = ~fifo_full;
  assign bus.in_en      = xfer;
  assign bus.iot_in     = msb_byte(shreg);
  assign bus.fn_sel     = fn_sel_q;
  assign bus.round_done = round_done_q;
endmodule

// File: doc/iot_stream_tx.md
# iot_stream_tx

Byte-serial transmitter feeding the IoT data-filter block. Accepts 128-bit data words plus a 3-bit function code over a valid/ready handshake. Buffers the words in a 2-entry FIFO and streams each word as 16 bytes, MSB byte first, on the filter's `in_en`/`iot_in` interface. It holds `fn_sel` stable for each round of 8 words and backs off while the filter raises `busy`.

## Interface
- `DEPTH`, 2: input FIFO entries (power of two, ≥2).
- `WORDS_PER_ROUND`, 8: words per `fn_sel` round.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `s_valid` in 1: upstream word valid.
- `s_ready` out 1: FIFO can accept; equals `!fifo_full`, registered.
- `s_data` in 128: data word.
- `s_fn` in 3: function code; meaningful only on the first word of a round.
- `busy` in 1: filter back-pressure; combinational from the filter.
- `in_en` out 1: byte strobe to the filter.
- `iot_in` out 8: byte to the filter, registered.
- `fn_sel` out 3: function select to the filter, registered.
- `round_done` out 1: one-cycle pulse after the last byte of a round has been transferred.

## Operation
- **Reset values:**
  - `in_en`=0, `iot_in`=0, `fn_sel`=0, `round_done`=0, `s_ready`=1.
  - FIFO empty, byte counter 0, word counter 0, FSM in IDLE.
- **Push:** a word and its `s_fn` are pushed on an edge with `s_valid & s_ready`. `s_ready` does not see a same-cycle pop: when the FIFO is full, a push waits one cycle after the pop.
- **FSM states:**
  - **IDLE:** if FIFO non-empty, pop into the 128-bit shift register, clear the byte counter, go to SEND.
  - **SEND:** `in_en = ~busy`, combinational gating of the registered send flag. A byte transfers on each edge where `in_en`=1.
    - On transfer, shift left by 8 and increment the byte counter (4 bits).
    - `iot_in` always shows `shreg[127:120]`.
    - While `busy`=1, the counter, shift register and `iot_in` hold.
  - **Word end:** the transfer with byte counter = 15 ends the word.
    - Word counter increments modulo `WORDS_PER_ROUND`.
    - If the FIFO is non-empty on that same edge, pop and stay in SEND. The next word's first byte follows with no bubble.
    - Otherwise go to IDLE.
- **Round handling:**
  - When a word is popped with word counter = 0, `fn_sel` loads that entry's fn.
  - `s_fn` of the other 7 words is ignored.
  - `fn_sel` holds until the next round's first pop, including across IDLE gaps.
  - `round_done` pulses in the cycle after the final byte of word 7 transfers.
- **Byte order:** bytes 127:120 first, 7:0 last, so the receiver's left-shift reconstructs the word.
- **Mid-operation reset:** clears everything asynchronously. Partial words and FIFO contents are discarded, and the next round starts at word 0.

## Timing
- **Latency, empty and idle:** word pushed at edge k, popped at edge k+1, first byte with `in_en`=1 in the cycle after edge k+1.
- **Throughput:** 16 cycles per word and 128 cycles per round with `busy`=0. There are no gaps while the FIFO stays non-empty.
- **`fn_sel` timing:** `fn_sel` changes on the same edge that presents byte 0 of a round. It is therefore valid in every cycle the filter samples `in_en`=1.
- **`busy` in IDLE:** `busy` asserted in IDLE has no effect.
- **Busy at a word boundary:** `busy` asserted on the final byte's cycle blocks that transfer. The pop happens on the first edge with `busy`=0.

## Structure
- Shared package `iotdf_pkg`:
  - function-code constants: MAX=1, MIN=2, AVG=3, EXTRACT=4, EXCLUDE=5, PEAKMAX=6, PEAKMIN=7;
  - `BYTES_PER_WORD`=16, `WORDS_PER_ROUND`=8;
  - a 131-bit FIFO entry typedef, {fn, data}.
- Sub-module `iot_tx_fifo`: parameterised synchronous FIFO with full/empty flags. Pop and push in the same cycle are legal when not full.

## Test plan
- **Single word:** reset, push 0x00112233_44556677_8899AABB_CCDDEEFF with fn=1 → 16 consecutive `in_en` cycles with `iot_in` = 00,11,…,FF; `fn_sel`=1 from byte 0; then `in_en`=0.
- **Full round, back-to-back:** push 8 words, fn=3 on word 0 and fn=5 on the others → 128 contiguous `in_en` cycles; `fn_sel`=3 throughout; `round_done` pulses once, in cycle 129.
- **Back-pressure:** hold `busy`=1 for 5 cycles starting at byte 7 → `in_en`=0 and `iot_in` stable at byte 7 for 5 cycles; all 16 bytes delivered in order, none duplicated.
- **FIFO full:** push 3 words while the first is sending → `s_ready`=0 after 2 buffered; it reasserts one cycle after the pop at word end; all 3 words emitted in order.
- **Round boundary fn:** after a completed round, push a word with fn=7 → `fn_sel` switches 3→7 exactly at that word's byte 0.
- **Reset mid-word:** assert `rst`=0 at byte 9 → `in_en`, `iot_in`, `fn_sel` go to 0 immediately; after release, the next push starts at byte 0 and word counter 0.
